// File: rtl/fp_div.sv
// Fixed-point signed divider Q = A/B (restoring, one quotient bit per cycle, fixed NITER+2 latency).
// Optional macro FP_DIV_ROUND_EN: round half away from zero instead of truncating toward zero.
module fp_div #(
  parameter int NB_IN_A  = 16,
  parameter int NBF_IN_A = 14,
  parameter int NB_IN_B  = 12,
  parameter int NBF_IN_B = 11,
  parameter int NB_OUT   = 12,
  parameter int NBF_OUT  = 11
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_IN_A-1:0]  i_A,
  input  logic [NB_IN_B-1:0]  i_B,
  output logic                o_busy,
  output logic                o_valid,
  output logic [NB_OUT-1:0]   o_Q,
  output logic                o_div0,
  output logic                o_sat
);

  localparam int SHIFT  = NBF_OUT + NBF_IN_B - NBF_IN_A + 1;
  localparam int NITER  = NB_IN_A + SHIFT;
  localparam int NB_CNT = $clog2(NITER + 1);

  localparam logic [NITER-1:0]  MAG_MAX_POS = NITER'((1 << (NB_OUT - 1)) - 1);
  localparam logic [NITER-1:0]  MAG_MAX_NEG = NITER'(1 << (NB_OUT - 1));
  localparam logic [NB_OUT-1:0] Q_MAX       = {1'b0, {(NB_OUT-1){1'b1}}};
  localparam logic [NB_OUT-1:0] Q_MIN       = {1'b1, {(NB_OUT-1){1'b0}}};

  generate
    if (SHIFT < 0) begin : g_bad_shift
      $error("fp_div: NBF_OUT + NBF_IN_B - NBF_IN_A + 1 must be >= 0");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t              r_state, w_next;
  logic [NB_CNT-1:0]   r_cnt;
  logic                r_sign, r_a_neg, r_b_zero;
  logic [NB_IN_B-1:0]  r_bmag;
  logic [NB_IN_B:0]    r_rem;
  logic [NITER-1:0]    r_quo;
  logic                r_valid, r_div0, r_sat;
  logic [NB_OUT-1:0]   r_q;

  logic [NB_IN_A-1:0]  w_a_mag;
  logic [NB_IN_B-1:0]  w_b_mag;
  logic [NB_IN_B:0]    w_trial, w_rem_nx;
  logic                w_ge;
  logic [NITER-1:0]    w_mag;
  logic [NB_OUT-1:0]   w_q;
  logic                w_sat;

  assign w_a_mag = i_A[NB_IN_A-1] ? -i_A : i_A;
  assign w_b_mag = i_B[NB_IN_B-1] ? -i_B : i_B;

  // r_quo shifts the dividend out at the top while quotient bits shift in at the bottom
  assign w_trial  = {r_rem[NB_IN_B-1:0], r_quo[NITER-1]};
  assign w_ge     = (w_trial >= {1'b0, r_bmag});
  assign w_rem_nx = w_ge ? (w_trial - {1'b0, r_bmag}) : w_trial;

`ifdef FP_DIV_ROUND_EN
  logic [NITER:0] w_sum;
  assign w_sum = {1'b0, r_quo} + (NITER+1)'(1);
  assign w_mag = w_sum[NITER:1];
`else
  assign w_mag = {1'b0, r_quo[NITER-1:1]};
`endif

  always_comb begin
    w_q   = '0;
    w_sat = 1'b0;
    if (r_b_zero) begin
      w_q   = r_a_neg ? Q_MIN : Q_MAX;
      w_sat = 1'b1;
    end else if (!r_sign) begin
      if (w_mag > MAG_MAX_POS) begin
        w_q   = Q_MAX;
        w_sat = 1'b1;
      end else begin
        w_q = w_mag[NB_OUT-1:0];
      end
    end else begin
      // a magnitude of exactly 2^(NB_OUT-1) negates to Q_MIN without clamping
      if (w_mag > MAG_MAX_NEG) begin
        w_q   = Q_MIN;
        w_sat = 1'b1;
      end else begin
        w_q = -w_mag[NB_OUT-1:0];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = DIV;
      DIV:     if (r_cnt == NB_CNT'(NITER - 1)) w_next = ROUND;
      ROUND:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sign   <= 1'b0;
      r_a_neg  <= 1'b0;
      r_b_zero <= 1'b0;
      r_bmag   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_valid  <= 1'b0;
      r_q      <= '0;
      r_div0   <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (r_state == DONE);
      case (r_state)
        IDLE: if (i_start) begin
          r_cnt    <= '0;
          r_sign   <= i_A[NB_IN_A-1] ^ i_B[NB_IN_B-1];
          r_a_neg  <= i_A[NB_IN_A-1];
          r_b_zero <= (i_B == '0);
          r_bmag   <= w_b_mag;
          r_rem    <= '0;
          r_quo    <= NITER'(w_a_mag) << SHIFT;
        end
        DIV: begin
          r_cnt <= r_cnt + 1'b1;
          r_rem <= w_rem_nx;
          r_quo <= {r_quo[NITER-2:0], w_ge};
        end
        ROUND: begin
          r_q    <= w_q;
          r_sat  <= w_sat;
          r_div0 <= r_b_zero;
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (r_state != IDLE);
  assign o_valid = r_valid;
  assign o_Q     = r_q;
  assign o_div0  = r_div0;
  assign o_sat   = r_sat;

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed corner cases, busy/reset handling and random operands vs. an arithmetic model.
module tb_fp_div;

  localparam int LAT = 27;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_A     = '0;
  logic [11:0] i_B     = '0;
  logic        o_busy, o_valid, o_div0, o_sat;
  logic [11:0] o_Q;

  int n_checks = 0;
  int n_errors = 0;

  fp_div dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (i_start),
    .i_A     (i_A),
    .i_B     (i_B),
    .o_busy  (o_busy),
    .o_valid (o_valid),
    .o_Q     (o_Q),
    .o_div0  (o_div0),
    .o_sat   (o_sat)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {div0, sat, Q} from plain integer arithmetic on the real values.
  function automatic logic [13:0] model(input logic [15:0] a, input logic [11:0] b);
    longint sa, sb, ma, mb, raw, mag;
    bit     neg;
    logic [11:0] q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return {1'b1, 1'b1, (sa < 0) ? 12'h800 : 12'h7FF};
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
    neg = (sa < 0) != (sb < 0);
    raw = (ma * 512) / mb;
`ifdef FP_DIV_ROUND_EN
    mag = (raw + 1) / 2;
`else
    mag = raw / 2;
`endif
    if (!neg && mag > 2047) return {1'b0, 1'b1, 12'h7FF};
    if (neg && mag > 2048)  return {1'b0, 1'b1, 12'h800};
    q = neg ? 12'(-mag) : 12'(mag);
    return {1'b0, 1'b0, q};
  endfunction

  task automatic do_op(input string tag, input logic [15:0] a, input logic [11:0] b);
    logic [13:0] exp;
    int          lat;
    bit          got;
    exp = model(a, b);
    @(negedge i_clock);
    i_A = a; i_B = b; i_start = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    i_A = $urandom; i_B = $urandom;
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
    lat = 0; got = 0;
    while (!got && lat < 100) begin
      @(posedge i_clock); #1;
      lat++;
      if (o_valid) got = 1;
    end
    chk({tag, "_lat"},  32'(lat),    32'(LAT));
    chk({tag, "_q"},    32'(o_Q),    32'(exp[11:0]));
    chk({tag, "_sat"},  32'(o_sat),  32'(exp[12]));
    chk({tag, "_div0"}, 32'(o_div0), 32'(exp[13]));
  endtask

  initial begin
    int          nval;
    logic [11:0] q_first;
    logic [15:0] ra;
    logic [11:0] rb;

    repeat (2) @(posedge i_clock);
    #1;
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_q",     32'(o_Q),     32'd0);
    chk("rst_sat",   32'(o_sat),   32'd0);
    chk("rst_div0",  32'(o_div0),  32'd0);
    @(negedge i_clock);
    i_reset = 1'b0;

    do_op("quarter_half", 16'h1000, 12'h400);
    chk("valid_pulse_before", 32'(o_valid), 32'd1);
    @(posedge i_clock); #1;
    chk("valid_one_cycle", 32'(o_valid), 32'd0);
    do_op("third",        16'h1000, 12'h600);
    do_op("neg_half",     16'hF000, 12'h400);
    do_op("minus_one",    16'hE000, 12'h400);
    do_op("plus_sat",     16'h2000, 12'h400);
    do_op("most_neg",     16'h8000, 12'h800);
    do_op("div0_pos",     16'h1000, 12'h000);
    do_op("div0_neg",     16'hF000, 12'h000);
    do_op("zero_neg_b",   16'h0000, 12'hC00);
    do_op("tiny_neg",     16'hFFFF, 12'h7FF);

    // start ignored while busy, operand changes ignored
    @(negedge i_clock);
    i_A = 16'h1000; i_B = 12'h600; i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    repeat (4) @(negedge i_clock);
    i_A = 16'h7FFF; i_B = 12'h123; i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    nval = 0; q_first = '0;
    for (int c = 0; c < 80; c++) begin
      @(posedge i_clock); #1;
      if (o_valid) begin
        if (nval == 0) q_first = o_Q;
        nval++;
      end
    end
    chk("busy_nvalid", 32'(nval),    32'd1);
    chk("busy_q",      32'(q_first), 32'(model(16'h1000, 12'h600) & 14'hFFF));

    // reset mid-operation aborts without a valid pulse
    @(negedge i_clock);
    i_A = 16'h2000; i_B = 12'h400; i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    repeat (8) @(negedge i_clock);
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    chk("abort_busy", 32'(o_busy),  32'd0);
    chk("abort_q",    32'(o_Q),     32'd0);
    chk("abort_sat",  32'(o_sat),   32'd0);
    chk("abort_div0", 32'(o_div0),  32'd0);
    @(negedge i_clock);
    i_reset = 1'b0;
    nval = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge i_clock); #1;
      if (o_valid) nval++;
    end
    chk("abort_nvalid", 32'(nval), 32'd0);
    do_op("after_abort", 16'h1000, 12'h400);

    // reset wins over a simultaneous start
    @(negedge i_clock);
    i_reset = 1'b1; i_start = 1'b1; i_A = 16'h1000; i_B = 12'h400;
    @(posedge i_clock); #1;
    chk("rst_prio_busy", 32'(o_busy), 32'd0);
    @(negedge i_clock);
    i_reset = 1'b0; i_start = 1'b0;

    for (int k = 0; k < 40; k++) begin
      ra = 16'($urandom);
      rb = 12'($urandom);
      if (k % 10 == 3) rb = '0;
      do_op($sformatf("rnd%0d", k), ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
